reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle RISC-V core.
- Two combinational read ports and one synchronous write port.
- Sits between instruction decode (register addresses) and ALU/writeback (operands and result).
- Register x0 is hardwired to zero, per RISC-V.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; number of registers = 2**ADDR_WIDTH (32).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; clears all registers.
- wEn  input  1  write enable.
- write_data  input  DATA_WIDTH  data to write into write_reg.
- read_reg1  input  ADDR_WIDTH  read port 1 address.
- read_reg2  input  ADDR_WIDTH  read port 2 address.
- write_reg  input  ADDR_WIDTH  write port address.
- read_data1  output  DATA_WIDTH  contents of read_reg1.
- read_data2  output  DATA_WIDTH  contents of read_reg2.

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits, clocked on the rising edge of clock only.
- Reset:
  - On a rising edge with reset=1, every register becomes 0.
  - Reset has priority over any write in the same cycle; the write is discarded.
  - While reset=1, read_data1 and read_data2 are driven to 0 combinationally.
- Write:
  - On a rising edge with reset=0, wEn=1 and write_reg != 0, register[write_reg] <= write_data.
  - wEn=0 leaves all registers unchanged.
  - A write to address 0 is ignored; x0 always reads 0.
- Read:
  - Purely combinational, zero-cycle latency.
  - read_dataN = register[read_regN]; read_regN == 0 always yields 0.
- Write-to-read forwarding:
  - Condition: reset=0, wEn=1, write_reg != 0 and write_reg == read_regN.
  - Then read_dataN = write_data combinationally in that same cycle.
  - Makes the new value visible before and after the write edge with no race.
- Simultaneous reads: both ports may address the same register; both return identical data.
- Unwritten registers after reset read 0.
- Before the first reset, register contents are undefined. Implementation may initialise to 0, but this is not required.
- No other state, no handshake, no stalls.

Test Plan:
- Reset=1 for one edge, then reset=0; read all 32 addresses on both ports -> every read returns 0x00000000.
- reset=0, wEn=1, write_reg=2, write_data=0x66208C33, read_reg1=2, read_reg2=5 -> read_data1=0x66208C33 (forwarded, then stored after edge); read_data2=0.
- Write reg6=0x00000004, then reg20=0x00000009 on consecutive edges, reading (2,6) then (20,2):
  - read_data2=4 in the first cycle.
  - read_data1=9 and read_data2=0x66208C33 in the second cycle.
  - reg2 is retained.
- reset=1, wEn=1, write_reg=7, write_data=4, read_reg1=7, read_reg2=5 -> outputs 0 during reset; after the edge reg7=0 and reg2/reg6/reg20 are cleared to 0.
- wEn=1, write_reg=0, write_data=0xFFFFFFFF; read_reg1=0 -> read_data1=0 before and after the edge.
- wEn=0, write_reg=3, write_data=0x12345678 after reg3 previously written with 0xA5A5A5A5 -> read_data on reg3 stays 0xA5A5A5A5.

Source files
------------

// File: rtl/reg_file.sv
// 32 x 32-bit RISC-V integer register file: two combinational read ports, one synchronous write port.
// x0 reads as zero, and a same-cycle write is forwarded to any read port that addresses it.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wEn,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic                  wr_valid_s;
  logic                  fwd1_s;
  logic                  fwd2_s;

  // Writes to x0 never take effect, so gate them out once here.
  always_comb begin
    wr_valid_s = 1'b0;
    if (wEn && (write_reg != ZERO_ADDR)) begin
      wr_valid_s = 1'b1;
    end else begin
      wr_valid_s = 1'b0;
    end
  end

  // Forwarding match per read port.
  always_comb begin
    fwd1_s = 1'b0;
    fwd2_s = 1'b0;
    if (!reset && wr_valid_s) begin
      fwd1_s = (write_reg == read_reg1);
      fwd2_s = (write_reg == read_reg2);
    end else begin
      fwd1_s = 1'b0;
      fwd2_s = 1'b0;
    end
  end

  // Register storage; reset wins over a write in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else if (wr_valid_s) begin
      regs_r[write_reg] <= write_data;
    end else begin
      regs_r[write_reg] <= regs_r[write_reg];
    end
  end

  // Read port 1.
  always_comb begin
    read_data1 = ZERO_DATA;
    if (reset || (read_reg1 == ZERO_ADDR)) begin
      read_data1 = ZERO_DATA;
    end else if (fwd1_s) begin
      read_data1 = write_data;
    end else begin
      read_data1 = regs_r[read_reg1];
    end
  end

  // Read port 2.
  always_comb begin
    read_data2 = ZERO_DATA;
    if (reset || (read_reg2 == ZERO_ADDR)) begin
      read_data2 = ZERO_DATA;
    end else if (fwd2_s) begin
      read_data2 = write_data;
    end else begin
      read_data2 = regs_r[read_reg2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed test-plan steps plus a randomized phase
// against a reference model, with expected reads queued at drive time and compared at sample time.
module tb_reg_file;

  logic        clock;
  logic        reset;
  logic        wEn;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];
  logic [31:0] model_r [32];
  int          n_checks;
  int          n_pass;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .wEn        (wEn),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle after the falling edge, queue its expectations, then sample before the rising edge.
  task automatic step(input logic rst, input logic wen, input logic [4:0] wreg,
                      input logic [31:0] wdata, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2, input string tag);
    logic [31:0] x1;
    logic [31:0] x2;
    @(negedge clock);
    reset = rst; wEn = wen; write_reg = wreg; write_data = wdata;
    read_reg1 = r1; read_reg2 = r2;
    exp_q1.push_back(e1);
    exp_q2.push_back(e2);
    #2;
    if (exp_q1.size() == 0 || exp_q2.size() == 0) begin
      check_value({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x1 = exp_q1.pop_front();
      x2 = exp_q2.pop_front();
      check_value({tag, "_rd1"}, read_data1, x1);
      check_value({tag, "_rd2"}, read_data2, x2);
    end
  endtask

  // Reference read: reset and x0 give zero, an active write to the same address is forwarded.
  function automatic logic [31:0] model_read(input logic rst, input logic wen, input logic [4:0] wreg,
                                             input logic [31:0] wdata, input logic [4:0] ra);
    if (rst || ra == 5'd0) return 32'd0;
    if (wen && wreg != 5'd0 && wreg == ra) return wdata;
    return model_r[ra];
  endfunction

  initial begin
    logic        rst;
    logic        wen;
    logic [4:0]  wreg;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] wdata;
    logic [31:0] e1;
    logic [31:0] e2;
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1; wEn = 1'b0; write_reg = 5'd0; write_data = 32'd0;
    read_reg1 = 5'd0; read_reg2 = 5'd0;

    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, "reset");
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 32'd0, 32'd0, "post_reset_zero");
    end

    step(1'b0, 1'b1, 5'd2, 32'h66208C33, 5'd2, 5'd5, 32'h66208C33, 32'd0, "fwd_reg2");
    step(1'b0, 1'b1, 5'd6, 32'h00000004, 5'd2, 5'd6, 32'h66208C33, 32'h00000004, "wr_reg6");
    step(1'b0, 1'b1, 5'd20, 32'h00000009, 5'd20, 5'd2, 32'h00000009, 32'h66208C33, "wr_reg20");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd20, 32'h00000004, 32'h00000009, "retain");

    step(1'b1, 1'b1, 5'd7, 32'h00000004, 5'd7, 5'd5, 32'd0, 32'd0, "reset_vs_write");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd2, 32'd0, 32'd0, "cleared_7_2");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd6, 5'd20, 32'd0, 32'd0, "cleared_6_20");

    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'd0, 32'd0, "x0_write");
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, "x0_after");

    step(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, "wr_reg3");
    step(1'b0, 1'b0, 5'd3, 32'h12345678, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, "wen_low");
    step(1'b0, 1'b0, 5'd3, 32'h12345678, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, "wen_low_after");

    // Randomized phase starts from a known cleared state.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, "rand_reset");
    for (int i = 0; i < 32; i++) model_r[i] = 32'd0;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 49) == 0);
      wen   = ($urandom_range(0, 3) != 0);
      wreg  = 5'($urandom_range(0, 31));
      wdata = $urandom;
      r1    = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
      r2    = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
      e1 = model_read(rst, wen, wreg, wdata, r1);
      e2 = model_read(rst, wen, wreg, wdata, r2);
      step(rst, wen, wreg, wdata, r1, r2, e1, e2, "rand");
      if (rst) begin
        for (int k = 0; k < 32; k++) model_r[k] = 32'd0;
      end else if (wen && wreg != 5'd0) begin
        model_r[wreg] = wdata;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
